// File: rtl/procesamiento_cmd_pkg.sv
// -----------------------------------------------------------------------------
// procesamiento_cmd_pkg
// Shared definitions for the SD command processing block:
//   - state_t          : command FSM state encoding
//   - RESP_*           : response_type codes
//   - START_BIT,
//     TRANSMISSION_BIT : leading bits of a host-to-card command token
//   - build_cmd()      : assembles the 40-bit command token
// -----------------------------------------------------------------------------
package procesamiento_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    CHECK     = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_48   = 2'b01;
  localparam logic [1:0] RESP_136  = 2'b10;

  localparam logic START_BIT        = 1'b0;
  localparam logic TRANSMISSION_BIT = 1'b1;

  localparam int unsigned CMD_W = 40;

  // Token sent to the physical layer; CRC and end bit are appended downstream.
  function automatic logic [CMD_W-1:0] build_cmd(input logic [5:0]  index,
                                                 input logic [31:0] argument);
    return {START_BIT, TRANSMISSION_BIT, index, argument};
  endfunction

endpackage

// File: rtl/procesamiento_cmd_contador_timeout.sv
// -----------------------------------------------------------------------------
// contador_timeout
// Saturating watchdog counter for waits on the SD physical layer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear, priority over enable
//   enable     : count one step per cycle
//   expired    : count has reached TIMEOUT_CYCLES-1 (counter stays there)
// -----------------------------------------------------------------------------
module contador_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/procesamiento_cmd.sv
// -----------------------------------------------------------------------------
// procesamiento_cmd
// Host-side SD command sequencer. Latches a host command, hands the 40-bit
// token to the physical layer with a strobe/ack handshake, optionally waits
// for a 48- or 136-bit response (4-phase strobe_in/ack_out), checks the echoed
// index of 48-bit responses and reports completion with error flags.
//
// Ports
//   sd_clock, reset          : clock, asynchronous active-low reset
//   new_command, cmd_index,
//   cmd_argument,
//   response_type            : host request (sampled in IDLE only)
//   busy, command_complete,
//   response_out,
//   timeout_error,
//   index_error, idle_out    : host status
//   cmd_to_send, strobe_out,
//   ack_in, no_response      : command path to the physical layer
//   strobe_in, response,
//   ack_out, command_timeout : response path from the physical layer
// -----------------------------------------------------------------------------
module procesamiento_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         new_command,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   response_type,
  output logic         busy,
  output logic         command_complete,
  output logic [127:0] response_out,
  output logic         timeout_error,
  output logic         index_error,
  output logic [39:0]  cmd_to_send,
  output logic         strobe_out,
  input  logic         ack_in,
  output logic         idle_out,
  output logic         no_response,
  input  logic         strobe_in,
  input  logic [127:0] response,
  output logic         ack_out,
  input  logic         command_timeout
);

  import procesamiento_cmd_pkg::*;

  state_t      state;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [1:0]  rtype_q;

  logic wd_enable;
  logic wd_clear;
  logic wd_expired;

  // The counter only runs in SEND/WAIT_RESP and is held at zero elsewhere, so
  // every entry into those states starts from zero. The only direct
  // SEND->WAIT_RESP hop is on ack_in, which clears it explicitly.
  assign wd_enable = (state == SEND) || (state == WAIT_RESP);
  assign wd_clear  = !wd_enable || ((state == SEND) && ack_in);

  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clk     (sd_clock),
    .rst_n   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      idx_q            <= '0;
      arg_q            <= '0;
      rtype_q          <= RESP_NONE;
      busy             <= 1'b0;
      command_complete <= 1'b0;
      response_out     <= '0;
      timeout_error    <= 1'b0;
      index_error      <= 1'b0;
      cmd_to_send      <= '0;
      strobe_out       <= 1'b0;
      idle_out         <= 1'b1;
      no_response      <= 1'b0;
      ack_out          <= 1'b0;
    end else begin
      command_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (new_command) begin
            idx_q         <= cmd_index;
            arg_q         <= cmd_argument;
            rtype_q       <= response_type;
            busy          <= 1'b1;
            idle_out      <= 1'b0;
            timeout_error <= 1'b0;
            index_error   <= 1'b0;
            state         <= LOAD;
          end
        end

        LOAD: begin
          cmd_to_send <= build_cmd(idx_q, arg_q);
          no_response <= (rtype_q == RESP_NONE);
          strobe_out  <= 1'b1;
          state       <= SEND;
        end

        SEND: begin
          if (ack_in) begin
            strobe_out <= 1'b0;
            if (no_response) begin
              command_complete <= 1'b1;
              state            <= FINISH;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (wd_expired) begin
            strobe_out       <= 1'b0;
            timeout_error    <= 1'b1;
            command_complete <= 1'b1;
            state            <= FINISH;
          end
        end

        WAIT_RESP: begin
          // A reported timeout overrides a simultaneous response strobe.
          if (command_timeout || wd_expired) begin
            timeout_error    <= 1'b1;
            command_complete <= 1'b1;
            state            <= FINISH;
          end else if (strobe_in) begin
            response_out <= response;
            ack_out      <= 1'b1;
            state        <= CHECK;
          end
        end

        CHECK: begin
          // 136-bit responses (R2) carry no index echo; reserved code 11
          // is checked like a 48-bit response.
          if (rtype_q == RESP_136) begin
            index_error <= 1'b0;
          end else begin
            index_error <= (response_out[45:40] != idx_q) || !response_out[0];
          end
          if (!strobe_in) begin
            ack_out <= 1'b0;
          end
          command_complete <= 1'b1;
          state            <= FINISH;
        end

        FINISH: begin
          if (!strobe_in) begin
            ack_out  <= 1'b0;
            busy     <= 1'b0;
            idle_out <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
